// File: rtl/nn_step_scheduler_pkg.sv
// Shared types and constants for the neural-navigator step scheduler.
// Used by nn_step_scheduler and nn_rr_arbiter.
// The optional watchdog is controlled by the NN_SCHED_WATCHDOG_EN macro.
package nn_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam int NUM_STEPS_DEF = 38;
    localparam int STEP_W_DEF    = 9;

    // A length of zero, or one beyond the maximum, runs the full phase sequence.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len = NUM_STEPS_DEF);
        if (len == 0 || len > max_len)
            return max_len;
        return len;
    endfunction

endpackage

// File: rtl/nn_step_scheduler_arb.sv
// Combinational round-robin picker for nn_step_scheduler.
// Returns the first active requester at or after the pointer, wrapping around.
// The pointer register is held by the parent.
module nn_rr_arbiter
    import nn_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any_req
);

    logic             w_found;
    logic [PTR_W-1:0] w_cand;

    // Add an offset to the pointer and wrap the result modulo NUM_REQ.
    function automatic int wrap_idx(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ)
            s = s - NUM_REQ;
        return s;
    endfunction

    // Scan the requesters in priority order, starting at the pointer.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = PTR_W'(wrap_idx(i_ptr, k));
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/nn_step_scheduler.sv
// Step scheduler for the 38-step neural-navigator phase sequence.
// It grants the shared sequencer to one requester at a time, walks the job through
// its steps with a valid/ready handshake, and then reports done or aborted.
// Optional watchdog: define NN_SCHED_WATCHDOG_EN to abort a job that has stalled
// for TIMEOUT_CYC cycles.
module nn_step_scheduler
    import nn_sched_pkg::*;
#(
    parameter int NUM_STEPS   = NUM_STEPS_DEF,
    parameter int STEP_W      = STEP_W_DEF,
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*STEP_W-1:0] req_len,
    input  logic                      abort,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [STEP_W-1:0]         step_idx,
    output logic                      step_valid,
    input  logic                      step_ready,
    output logic                      done,
    output logic                      aborted,
    output logic                      timeout
);

    localparam int PTR_W = $clog2(NUM_REQ);

    sched_state_t        r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_busy;
    logic [STEP_W-1:0]   r_step;
    logic                r_valid;
    logic                r_done;
    logic                r_aborted;
    logic                r_timeout;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_owner;
    logic [STEP_W-1:0]   r_len;

    logic [NUM_REQ-1:0]  w_arb_grant;
    logic [PTR_W-1:0]    w_arb_idx;
    logic                w_any_req;
    logic [STEP_W-1:0]   w_len_sel;
    logic [STEP_W-1:0]   w_len_clamped;
    logic                w_start;
    logic                w_handshake;
    logic                w_last;
    logic                w_abort;
    logic                w_wd_fire;
    logic [PTR_W-1:0]    w_owner_next;

    nn_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_grant   (w_arb_grant),
        .o_idx     (w_arb_idx),
        .o_any_req (w_any_req)
    );

    // A global abort in IDLE blocks arbitration for that cycle.
    assign w_start       = (r_state == IDLE) && w_any_req && !abort;
    assign w_len_sel     = req_len[int'(w_arb_idx)*STEP_W +: STEP_W];
    assign w_len_clamped = STEP_W'(clamp_len(32'(w_len_sel), 32'(NUM_STEPS)));

    assign w_handshake   = r_valid && step_ready;
    assign w_last        = (r_step == r_len - 1'b1);
    // Abort sources, evaluated only while a job is running.
    assign w_abort       = abort || !req[r_owner] || w_wd_fire;
    assign w_owner_next  = (r_owner == PTR_W'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;

`ifdef NN_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wd;

    // Count consecutive stalled cycles of the current step. The count clears outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wd <= '0;
        else if (r_state != RUN || w_handshake)
            r_wd <= '0;
        else if (r_valid)
            r_wd <= r_wd + 1'b1;
    end

    // Fire on the stalled cycle that brings the count to TIMEOUT_CYC.
    assign w_wd_fire = (r_state == RUN) && r_valid && !step_ready &&
                       (r_wd == WD_W'(TIMEOUT_CYC - 1));
`else
    assign w_wd_fire = 1'b0;
`endif

    // Capture the owner and its clamped length when a job is granted. Changes to req_len later are ignored.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_owner <= w_arb_idx;
            r_len   <= w_len_clamped;
        end
    end

    // Main control FSM. All outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_step    <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= RUN;
                        r_grant <= w_arb_grant;
                        r_busy  <= 1'b1;
                        r_step  <= '0;
                        r_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        // Abort takes priority over a final handshake in the same cycle.
                        r_state   <= IDLE;
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_step    <= '0;
                        r_valid   <= 1'b0;
                        r_aborted <= 1'b1;
                        r_timeout <= w_wd_fire;
                        r_ptr     <= w_owner_next;
                    end else if (w_handshake) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_step  <= '0;
                    r_ptr   <= w_owner_next;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_step  <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign busy       = r_busy;
    assign step_idx   = r_step;
    assign step_valid = r_valid;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_nn_step_scheduler.sv
// Scoreboard testbench for nn_step_scheduler.
// Stimulus pushes the expected events (step handshakes, done and abort) into a queue.
// A negedge monitor pops an entry and compares it each time the DUT produces an event.
module tb_nn_step_scheduler;

    localparam int NR = 2;
    localparam int SW = 9;
`ifdef NN_SCHED_WATCHDOG_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*SW-1:0] req_len = '0;
    logic             abort = 1'b0;
    logic [NR-1:0]    grant;
    logic             busy;
    logic [SW-1:0]    step_idx;
    logic             step_valid;
    logic             step_ready = 1'b0;
    logic             done;
    logic             aborted;
    logic             timeout;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [NR-1:0] prev_g = '0;

    always #5 clk = ~clk;

    nn_step_scheduler #(
        .NUM_STEPS   (38),
        .STEP_W      (SW),
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_len    (req_len),
        .abort      (abort),
        .grant      (grant),
        .busy       (busy),
        .step_idx   (step_idx),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .done       (done),
        .aborted    (aborted),
        .timeout    (timeout)
    );

    // Event kinds: 1=step handshake, 2=done, 3=abort, 4=abort with timeout, 5=timeout alone.
    function automatic logic [31:0] ev(input int kind, input logic [NR-1:0] g, input logic [SW-1:0] idx);
        return {8'(kind), 8'(g), 16'(idx)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic see(input logic [31:0] a);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL event: got 0x%0h expected none at %0t", a, $time);
        end else begin
            chk("event", a, exp_q.pop_front());
        end
    endtask

    // Monitor: log every DUT event and make sure a grant always drops to zero before it changes.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_g <= '0;
        end else begin
            if (step_valid && step_ready) see(ev(1, grant, step_idx));
            if (done) see(ev(2, grant, '0));
            if (aborted) see(ev(timeout ? 4 : 3, grant, '0));
            else if (timeout) see(ev(5, grant, '0));
            if (prev_g != '0 && grant != prev_g) chk("grant_release", 32'(grant), 32'd0);
            prev_g <= grant;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setlen(input int r, input int v);
        req_len[r*SW +: SW] = SW'(v);
    endtask

    task automatic push_steps(input logic [NR-1:0] g, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ev(1, g, SW'(i)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; abort = 1'b0; step_ready = 1'b0; req_len = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic finish_job();
        req = '0;
        abort = 1'b0;
        tick();
        tick();
    endtask

    // Wait until done or aborted appears. n counts the cycles waited.
    task automatic wait_end(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(done || aborted) && n < 200);
        if (!(done || aborted)) begin
            total++;
            bad++;
            $display("FAIL wait_end: got no done/aborted expected one within 200 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int ok;

        do_reset();
        chk("reset_outputs", 32'({grant, busy, step_idx, step_valid, done, aborted, timeout}), 32'd0);

        // Single job with length 5.
        setlen(0, 5); step_ready = 1'b1;
        push_steps(2'b01, 5); exp_q.push_back(ev(2, 2'b01, '0));
        req = 2'b01;
        tick();
        chk("t1_grant", 32'(grant), 32'd1);
        wait_end(n);
        req = '0;
        chk("t1_done_lat", n, 5);
        tick();
        chk("t1_release", 32'({grant, busy}), 32'd0);

        // Round-robin: both requesters active, length 3 each.
        do_reset();
        setlen(0, 3); setlen(1, 3); step_ready = 1'b1;
        push_steps(2'b01, 3); exp_q.push_back(ev(2, 2'b01, '0));
        push_steps(2'b10, 3); exp_q.push_back(ev(2, 2'b10, '0));
        push_steps(2'b01, 3); exp_q.push_back(ev(2, 2'b01, '0));
        req = 2'b11;
        tick();
        chk("t2_grant0", 32'(grant), 32'd1);
        wait_end(n);
        tick();
        chk("t2_gap1", 32'(grant), 32'd0);
        tick();
        chk("t2_grant1", 32'(grant), 32'd2);
        wait_end(n);
        tick();
        chk("t2_gap2", 32'(grant), 32'd0);
        tick();
        chk("t2_grant2", 32'(grant), 32'd1);
        wait_end(n);
        finish_job();

        // Backpressure: step_ready low for 3 cycles at step 2.
        do_reset();
        setlen(0, 4); step_ready = 1'b1;
        push_steps(2'b01, 4); exp_q.push_back(ev(2, 2'b01, '0));
        req = 2'b01;
        tick(); tick(); tick();
        step_ready = 1'b0;
        chk("t3_hold_a", 32'(step_idx), 32'd2);
        tick();
        chk("t3_hold_b", 32'(step_idx), 32'd2);
        tick();
        chk("t3_hold_c", 32'(step_idx), 32'd2);
        tick();
        chk("t3_hold_d", 32'(step_idx), 32'd2);
        step_ready = 1'b1;
        wait_end(n);
        chk("t3_done_lat", n, 2);
        finish_job();

        // Clamp: length 0 on requester 1 runs 38 steps.
        setlen(1, 0);
        push_steps(2'b10, 38); exp_q.push_back(ev(2, 2'b10, '0));
        req = 2'b10;
        tick();
        chk("t4_grant", 32'(grant), 32'd2);
        wait_end(n);
        chk("t4_len0_cycles", n, 38);
        finish_job();

        // Clamp: length 50 runs 38 steps.
        setlen(0, 50);
        push_steps(2'b01, 38); exp_q.push_back(ev(2, 2'b01, '0));
        req = 2'b01;
        tick();
        chk("t5_grant", 32'(grant), 32'd1);
        wait_end(n);
        chk("t5_len50_cycles", n, 38);
        finish_job();

        // Length 1.
        setlen(0, 1);
        push_steps(2'b01, 1); exp_q.push_back(ev(2, 2'b01, '0));
        req = 2'b01;
        tick();
        wait_end(n);
        chk("t6_len1_lat", n, 1);
        finish_job();

        // Global abort at step 3.
        setlen(0, 10);
        push_steps(2'b01, 4); exp_q.push_back(ev(3, 2'b00, '0));
        req = 2'b01;
        tick(); tick(); tick(); tick();
        chk("t7_idx", 32'(step_idx), 32'd3);
        abort = 1'b1;
        tick();
        chk("t7_abort", 32'({aborted, done, grant}), 32'b1000);
        finish_job();

        // The requester drops req at step 2.
        setlen(0, 10);
        push_steps(2'b01, 3); exp_q.push_back(ev(3, 2'b00, '0));
        req = 2'b01;
        tick(); tick(); tick();
        chk("t8_idx", 32'(step_idx), 32'd2);
        req = 2'b00;
        tick();
        chk("t8_drop", 32'({aborted, done, grant}), 32'b1000);
        finish_job();

        // Abort in the same cycle as the last handshake.
        setlen(0, 4);
        push_steps(2'b01, 4); exp_q.push_back(ev(3, 2'b00, '0));
        req = 2'b01;
        tick(); tick(); tick(); tick();
        chk("t9_idx", 32'(step_idx), 32'd3);
        abort = 1'b1;
        tick();
        chk("t9_abort_wins", 32'({aborted, done}), 32'b10);
        finish_job();

        // Abort while IDLE blocks the grant.
        setlen(0, 2);
        push_steps(2'b01, 2); exp_q.push_back(ev(2, 2'b01, '0));
        abort = 1'b1; req = 2'b01;
        tick();
        chk("t10_no_grant", 32'(grant), 32'd0);
        abort = 1'b0;
        tick();
        chk("t10_grant", 32'(grant), 32'd1);
        wait_end(n);
        finish_job();

        // Stuck step_ready: the watchdog aborts if compiled in; otherwise the step waits.
        setlen(0, 3); step_ready = 1'b0;
        req = 2'b01;
`ifdef NN_SCHED_WATCHDOG_EN
        exp_q.push_back(ev(4, 2'b00, '0));
        tick();
        chk("t11_grant", 32'(grant), 32'd1);
        wait_end(n);
        chk("t11_wd_cycles", n, TO);
        step_ready = 1'b1;
        finish_job();
`else
        tick();
        chk("t11_grant", 32'(grant), 32'd1);
        ok = 1;
        repeat (300) begin
            tick();
            if (!step_valid || timeout || step_idx != '0) ok = 0;
        end
        chk("t11_no_watchdog", ok, 1);
        push_steps(2'b01, 3); exp_q.push_back(ev(2, 2'b01, '0));
        step_ready = 1'b1;
        wait_end(n);
        finish_job();
`endif

        // Asynchronous reset in the middle of a job.
        setlen(0, 10); step_ready = 1'b1;
        push_steps(2'b01, 1);
        req = 2'b01;
        tick();
        tick();
        chk("t12_running", 32'(step_idx), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t12_async_rst", 32'({grant, busy, step_idx, step_valid, done, aborted, timeout}), 32'd0);
        req = '0;
        tick();
        rst_n = 1'b1;
        tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_step_scheduler.md
Name: nn_step_scheduler

Overview:
- Controls the 38-step neural-navigator phase sequence.
- Grants the shared step sequencer to one of NUM_REQ requesters using round-robin arbitration.
- Walks the granted job through its programmed number of steps, with a valid/ready handshake to the datapath on every step.
- Reports completion or abort, then releases the resource.

Parameters:
- NUM_STEPS, 38: maximum steps per job. Also the length used when a requested length is out of range.
- STEP_W, 9: width of the step index and length fields.
- NUM_REQ, 2: number of requesters. Legal range 2..8.
- TIMEOUT_CYC, 255: watchdog limit in cycles. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- req  in  NUM_REQ  per-requester job request, level; held high for the whole job.
- req_len  in  NUM_REQ*STEP_W  per-requester job length, flattened; requester i uses bits [i*STEP_W +: STEP_W].
- abort  in  1  global abort, synchronous.
- grant  out  NUM_REQ  one-hot owner of the sequencer; zero when idle.
- busy  out  1  high in RUN and DONE.
- step_idx  out  STEP_W  current step, counting 0..len-1.
- step_valid  out  1  step_idx is valid for the datapath.
- step_ready  in  1  datapath accepts the current step.
- done  out  1  one-cycle pulse: job completed normally.
- aborted  out  1  one-cycle pulse: job terminated early.
- timeout  out  1  one-cycle pulse: watchdog fired. Tied 0 when the feature is absent.

Behaviour:
- Reset values: grant=0, busy=0, step_idx=0, step_valid=0, done=0, aborted=0, timeout=0, RR pointer=0, state=IDLE. All outputs are registered.
- State IDLE:
  - If any req is high, select the first requester at or after the RR pointer, wrapping modulo NUM_REQ.
  - Latch its length. If len==0 or len>NUM_STEPS, latch NUM_STEPS instead.
  - Next cycle: state=RUN, grant=onehot(i), step_idx=0, step_valid=1. Latency from req high to grant is exactly 1 cycle.
- State RUN:
  - step_valid=1 throughout.
  - On step_valid&&step_ready with step_idx<len-1: step_idx increments.
  - On the handshake with step_idx==len-1: state=DONE, step_valid=0.
  - When step_ready is low, step_idx holds.
- State DONE:
  - Lasts exactly 1 cycle: done=1, grant still held, step_idx holds the last value.
  - Then IDLE with grant=0 and step_idx=0.
  - RR pointer becomes (i+1) mod NUM_REQ.
- Abort in RUN: state goes to IDLE in the next cycle, with grant=0, step_valid=0, step_idx=0 and aborted=1 for 1 cycle. RR pointer advances as for DONE. Any of the following triggers it:
  - abort=1;
  - the granted requester's req going low;
  - the watchdog (optional feature).
- Simultaneous events:
  - Abort and the final handshake in the same cycle: abort wins; aborted=1, done=0.
  - abort=1 while in IDLE: no grant is issued that cycle.
  - Requests from other requesters are ignored until IDLE. Arbitration happens only in IDLE, so a new job can start no earlier than the cycle after DONE or abort; there is no back-to-back grant.
- Changes to req_len while RUN have no effect.
- rst_n assertion mid-job returns everything to reset values immediately and asynchronously.
- len==1: a single handshake goes straight to DONE.

Optional Feature:
- Macro: NN_SCHED_WATCHDOG_EN.
- Defined:
  - A counter clears on every handshake and on entry to RUN.
  - It increments each RUN cycle with step_valid&&!step_ready.
  - On reaching TIMEOUT_CYC it causes an abort, and timeout=1 together with aborted=1 in the same cycle.
- Undefined: no counter exists and timeout is constant 0. TIMEOUT_CYC is unused.

Decomposition:
- Package nn_sched_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - default constants NUM_STEPS_DEF=38 and STEP_W_DEF=9;
  - a function clamp_len(len) implementing the length rule.
- Sub-module nn_rr_arbiter:
  - combinational one-hot pick from req and the RR pointer, plus an any_req output;
  - pointer storage stays in the parent.

Test Plan:
- Single job: req=2'b01, len0=5, step_ready=1 → grant=01 at cycle 1; step_idx 0,1,2,3,4 on cycles 1..5; done=1 at cycle 6; grant=0 at cycle 7.
- Round-robin: req=2'b11 held, len=3 each, step_ready=1 → grants alternate 01, 10, 01; a one-cycle IDLE gap between jobs; no grant overlap.
- Backpressure: len=4 with step_ready low for 3 cycles at step 2 → step_idx holds at 2 for 3 cycles; done after 4 handshakes in total.
- Clamp and edges:
  - len=0 → 38 handshakes, last step_idx=37, then done.
  - len=50 → same.
  - len=1 → done 1 cycle after the first handshake.
- Abort paths:
  - abort at step 3 → aborted pulse, grant=0 next cycle, no done.
  - Requester dropping req at step 2 → same response.
  - abort coincident with the last handshake → aborted=1, done=0.
  - rst_n low mid-job → all outputs 0 immediately.
- Watchdog (macro defined, TIMEOUT_CYC=8): step_ready stuck low → timeout=1 and aborted=1 after 8 stalled cycles. Macro undefined: step_valid stays high indefinitely and timeout stays 0.
